line_frequency_measure: RTL and testbench
=========================================

# line_frequency_measure

Converts one image line of pixel intensities into per-pixel square waves and measures each wave's timing. Pixel data arrives over a single serial bit and is captured into a line register by a load strobe. Each pixel drives a programmable-frequency generator, whose output feeds a high/low/period cycle counter. The block sits between the serial readout front end and the measurement capture logic.

## Interface
- NUM_PIXELS, 1024, pixels per line
- PIXEL_BITS, 8, bits per pixel
- COUNTER_BITS, 15, width of each measurement field
- CLOCK_FREQ, 50_000_000, CLK frequency in Hz
- LOW_FREQ, 10_001, output frequency in Hz for pixel value 0
- HIGH_FREQ, 20_000_000, target output frequency in Hz for pixel value 2^PIXEL_BITS-1

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous and active-high
- SHIFT_IN  in  1  serial line data, MSB of the line first
- LOAD  in  1  one-cycle strobe that transfers the shift stage to DATA_OUT
- DATA_OUT  out  NUM_PIXELS*PIXEL_BITS  loaded line; pixel i = DATA_OUT[PIXEL_BITS*i +: PIXEL_BITS]
- FREQ_OUT  out  NUM_PIXELS  per-pixel square wave
- TIME_HIGH  out  NUM_PIXELS*COUNTER_BITS  last measured high time, in CLK cycles, for pixel i in field [COUNTER_BITS*i +: COUNTER_BITS]
- TIME_LOW  out  same  last measured low time
- PERIOD  out  same  last measured period

## Operation
- Shift stage:
  - When LOAD=0: shift left by one and insert SHIFT_IN at bit 0.
  - When LOAD=1: hold the shift stage and copy it to DATA_OUT.
  - LOAD has priority over shifting.
- The last pixel shifted in is pixel 0.
- Generator, per pixel:
  - Half-period HP(v) = HP_MAX - floor((HP_MAX-HP_MIN)*v / (2^PIXEL_BITS-1)).
  - HP_MAX = floor(CLOCK_FREQ/(2*LOW_FREQ)).
  - HP_MIN = max(1, floor(CLOCK_FREQ/(2*HIGH_FREQ))).
  - With defaults: HP(0)=2499, HP(128)=1246, HP(255)=1.
- The generator toggles FREQ_OUT every HP cycles.
- When the DATA_OUT pixel value changes, the generator latches the new HP and restarts: its count clears and FREQ_OUT is forced to 0.
- Counter, per pixel:
  - Registers FREQ_IN and counts CLK cycles spent high and low.
  - On a rising edge it commits TIME_HIGH, TIME_LOW and PERIOD = high+low of the completed cycle, then restarts counting.
  - On a falling edge it latches the high count.
- The first rising edge after reset only arms the counter; no commit occurs.
- Internal counts saturate at 2^COUNTER_BITS-1 and never wrap.
- If FREQ_IN stays constant, the outputs hold their last values.
- Steady state for value v: TIME_HIGH = TIME_LOW = HP(v), PERIOD = 2*HP(v).

## Timing
- While RST is high: the shift stage, DATA_OUT, FREQ_OUT, all counts, TIME_HIGH, TIME_LOW and PERIOD are 0, and the counters are disarmed.
- Reset mid-line discards all partial shift and measurement state.
- DATA_OUT is valid 1 cycle after the LOAD edge.
- The generator restarts on the cycle after DATA_OUT changes.
- FREQ_OUT is registered, and the counter adds 1 more cycle of edge-detect latency.
- The first valid measurement appears within 2*PERIOD + 3 cycles after LOAD.
- A full line load takes NUM_PIXELS*PIXEL_BITS shift cycles plus 1 LOAD cycle.

## Configuration
- LFM_CLEAR_ON_LOAD_EN defined: a LOAD cycle also zeroes TIME_HIGH, TIME_LOW, PERIOD and the internal counts, and disarms every counter. Stale measurements never survive a new line.
- Not defined: measurement outputs hold their previous values until the first complete new cycle commits.

## Structure
- Package lfm_pkg:
  - default parameter constants;
  - the HP computation function, evaluated at elaboration into a 2^PIXEL_BITS-entry constant table;
  - localparam MAX_COUNT = 2^COUNTER_BITS-1.
- Sub-module line_pixel_channel: one generator plus one counter, instantiated NUM_PIXELS times in a generate loop.
- The shift stage is inline in the top level.

## Test plan
Use NUM_PIXELS=4 unless stated otherwise.
- Reset: assert RST mid-shift -> all outputs 0; after release, no measurement commits before the second rising edge of FREQ_OUT.
- Shift/load: serially shift 32'hFF80_0010 MSB first, then pulse LOAD -> DATA_OUT = 32'hFF80_0010 one cycle later, with pixel 0 = 8'h10 and pixel 3 = 8'hFF.
- Measurement: load pixels {8'hFF, 8'h80, 8'h00, 8'h00} (pixel 3 down to pixel 0), wait 12000 cycles:
  - pixel 3 (0xFF): PERIOD = 2, TIME_HIGH = TIME_LOW = 1;
  - pixel 2 (0x80): PERIOD = 2492;
  - pixel 1 (0x00): PERIOD = 4998.
- Saturation: set COUNTER_BITS=8 with pixel 0 -> PERIOD = 255 and TIME_HIGH = TIME_LOW = 255; no wrap.
- LOAD priority: drive SHIFT_IN=1 during the LOAD cycle -> the shift stage is unchanged that cycle.
- Macro: with LFM_CLEAR_ON_LOAD_EN, LOAD -> PERIOD = 0 on the next cycle. Without it, PERIOD keeps its old value until the new period commits.

Source files
------------

// File: rtl/lfm_pkg.sv
// -----------------------------------------------------------------------------
// lfm_pkg
// Shared constants, types and elaboration-time helpers for line_frequency_measure.
//   - DEF_* : default values for the top-level parameters
//   - MAX_COUNT : saturation ceiling of a measurement field at the default width
//   - edge_kind_e : classification of the sampled square wave per cycle
//   - lfm_hp_max / lfm_hp : half-period (in clock cycles) for a pixel value;
//     only ever called with constant arguments to build a lookup table.
// -----------------------------------------------------------------------------
package lfm_pkg;

    localparam int DEF_NUM_PIXELS   = 1024;
    localparam int DEF_PIXEL_BITS   = 8;
    localparam int DEF_COUNTER_BITS = 15;
    localparam int DEF_CLOCK_FREQ   = 50_000_000;
    localparam int DEF_LOW_FREQ     = 10_001;
    localparam int DEF_HIGH_FREQ    = 20_000_000;

    localparam int MAX_COUNT = (32'sd1 << DEF_COUNTER_BITS) - 32'sd1;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_e;

    // Longest half-period: the one used for pixel value 0.
    function automatic int unsigned lfm_hp_max(
        input int unsigned clock_freq,
        input int unsigned low_freq
    );
        longint unsigned hp_max;
        hp_max = 64'(clock_freq) / (64'd2 * 64'(low_freq));
        return 32'(hp_max);
    endfunction

    // Half-period for one pixel value. Linear from HP_MAX (value 0) down to
    // HP_MIN (full-scale value); HP_MIN never drops below one cycle so the
    // generator always has a legal toggle interval.
    function automatic int unsigned lfm_hp(
        input int unsigned value,
        input int unsigned pixel_bits,
        input int unsigned clock_freq,
        input int unsigned low_freq,
        input int unsigned high_freq
    );
        longint unsigned hp_max;
        longint unsigned hp_min;
        longint unsigned span;
        longint unsigned full_scale;
        hp_max     = 64'(lfm_hp_max(clock_freq, low_freq));
        hp_min     = 64'(clock_freq) / (64'd2 * 64'(high_freq));
        if (hp_min < 64'd1) begin
            hp_min = 64'd1;
        end
        full_scale = (64'd1 << pixel_bits) - 64'd1;
        span       = (hp_max > hp_min) ? (hp_max - hp_min) : 64'd0;
        return 32'(hp_max - ((span * 64'(value)) / full_scale));
    endfunction

endpackage

// File: rtl/line_pixel_channel.sv
// -----------------------------------------------------------------------------
// line_pixel_channel
// One pixel's square-wave generator followed by its high/low/period counter.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : zeroes the measurement state and disarms the counter
//   pixel       : current pixel value from the line register
//   hp          : half-period matching 'pixel' (from the constant table)
//   freq_out    : registered square wave
//   time_high   : last committed high time in clock cycles
//   time_low    : last committed low time in clock cycles
//   period      : last committed high+low, saturating
// -----------------------------------------------------------------------------
module line_pixel_channel
    import lfm_pkg::*;
#(
    parameter int              PIXEL_BITS   = DEF_PIXEL_BITS,
    parameter int              COUNTER_BITS = DEF_COUNTER_BITS,
    parameter int              HP_W         = 12,
    parameter logic [HP_W-1:0] HP_RESET     = {HP_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [PIXEL_BITS-1:0]   pixel,
    input  logic [HP_W-1:0]         hp,
    output logic                    freq_out,
    output logic [COUNTER_BITS-1:0] time_high,
    output logic [COUNTER_BITS-1:0] time_low,
    output logic [COUNTER_BITS-1:0] period
);

    localparam logic [COUNTER_BITS-1:0] CNT_MAX = {COUNTER_BITS{1'b1}};
    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);
    localparam logic [HP_W-1:0]         HP_ONE  = HP_W'(1);

    // generator state
    logic [PIXEL_BITS-1:0]   pixel_r;
    logic [HP_W-1:0]         hp_r;
    logic [HP_W-1:0]         gen_cnt_r;
    logic                    freq_r;
    logic                    restart_s;

    // counter state
    logic                    in_r;
    logic                    armed_r;
    logic [COUNTER_BITS-1:0] run_r;
    logic [COUNTER_BITS-1:0] high_lat_r;
    logic [COUNTER_BITS-1:0] time_high_r;
    logic [COUNTER_BITS-1:0] time_low_r;
    logic [COUNTER_BITS-1:0] period_r;

    edge_kind_e              edge_s;
    logic [COUNTER_BITS:0]   sum_wide_s;
    logic [COUNTER_BITS-1:0] period_sum_s;
    logic [COUNTER_BITS-1:0] run_inc_s;

    // A pixel differing from the latched copy means the line register changed.
    assign restart_s = (pixel != pixel_r);

    // Square-wave generator: toggle every hp_r cycles, restart low on a new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_r   <= '0;
            hp_r      <= HP_RESET;
            gen_cnt_r <= '0;
            freq_r    <= 1'b0;
        end else if (restart_s) begin
            pixel_r   <= pixel;
            hp_r      <= hp;
            gen_cnt_r <= '0;
            freq_r    <= 1'b0;
        end else if (gen_cnt_r >= (hp_r - HP_ONE)) begin
            gen_cnt_r <= '0;
            freq_r    <= ~freq_r;
        end else begin
            gen_cnt_r <= gen_cnt_r + HP_ONE;
        end
    end

    // Classify this cycle's generator level against the registered copy.
    always_comb begin
        edge_s = EDGE_NONE;
        if (freq_r && !in_r) begin
            edge_s = EDGE_RISE;
        end else if (!freq_r && in_r) begin
            edge_s = EDGE_FALL;
        end else begin
            edge_s = EDGE_NONE;
        end
    end

    // Saturating increment of the running count and saturating period sum.
    always_comb begin
        sum_wide_s = {1'b0, high_lat_r} + {1'b0, run_r};
        if (sum_wide_s[COUNTER_BITS]) begin
            period_sum_s = CNT_MAX;
        end else begin
            period_sum_s = sum_wide_s[COUNTER_BITS-1:0];
        end
        if (run_r == CNT_MAX) begin
            run_inc_s = CNT_MAX;
        end else begin
            run_inc_s = run_r + CNT_ONE;
        end
    end

    // Measurement counter: run_r counts the current phase including its first
    // cycle; a fall parks the high count, a rise commits the finished cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r        <= 1'b0;
            armed_r     <= 1'b0;
            run_r       <= '0;
            high_lat_r  <= '0;
            time_high_r <= '0;
            time_low_r  <= '0;
            period_r    <= '0;
        end else if (clear) begin
            // keep tracking the level so no phantom edge appears afterwards
            in_r        <= freq_r;
            armed_r     <= 1'b0;
            run_r       <= '0;
            high_lat_r  <= '0;
            time_high_r <= '0;
            time_low_r  <= '0;
            period_r    <= '0;
        end else begin
            in_r <= freq_r;
            case (edge_s)
                EDGE_RISE: begin
                    // the partial cycle seen before arming is never reported
                    if (armed_r) begin
                        time_high_r <= high_lat_r;
                        time_low_r  <= run_r;
                        period_r    <= period_sum_s;
                    end
                    armed_r <= 1'b1;
                    run_r   <= CNT_ONE;
                end
                EDGE_FALL: begin
                    high_lat_r <= run_r;
                    run_r      <= CNT_ONE;
                end
                default: begin
                    run_r <= run_inc_s;
                end
            endcase
        end
    end

    assign freq_out  = freq_r;
    assign time_high = time_high_r;
    assign time_low  = time_low_r;
    assign period    = period_r;

endmodule

// File: rtl/line_frequency_measure.sv
// -----------------------------------------------------------------------------
// line_frequency_measure
// Captures a serially shifted image line and turns every pixel into a square
// wave whose high time, low time and period are measured in clock cycles.
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   SHIFT_IN   : serial line data, MSB of the line first (pixel 0 arrives last)
//   LOAD       : one-cycle strobe copying the shift stage to DATA_OUT
//   DATA_OUT   : loaded line, pixel i at [PIXEL_BITS*i +: PIXEL_BITS]
//   FREQ_OUT   : per-pixel square wave
//   TIME_HIGH  : per-pixel last high time, field [COUNTER_BITS*i +: COUNTER_BITS]
//   TIME_LOW   : per-pixel last low time, same layout
//   PERIOD     : per-pixel last period, same layout
// Build option: LFM_CLEAR_ON_LOAD_EN makes each LOAD cycle also wipe every
// channel's measurements and disarm its counter.
// -----------------------------------------------------------------------------
module line_frequency_measure
    import lfm_pkg::*;
#(
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
    parameter int PIXEL_BITS   = DEF_PIXEL_BITS,
    parameter int COUNTER_BITS = DEF_COUNTER_BITS,
    parameter int CLOCK_FREQ   = DEF_CLOCK_FREQ,
    parameter int LOW_FREQ     = DEF_LOW_FREQ,
    parameter int HIGH_FREQ    = DEF_HIGH_FREQ
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               SHIFT_IN,
    input  logic                               LOAD,
    output logic [NUM_PIXELS*PIXEL_BITS-1:0]   DATA_OUT,
    output logic [NUM_PIXELS-1:0]              FREQ_OUT,
    output logic [NUM_PIXELS*COUNTER_BITS-1:0] TIME_HIGH,
    output logic [NUM_PIXELS*COUNTER_BITS-1:0] TIME_LOW,
    output logic [NUM_PIXELS*COUNTER_BITS-1:0] PERIOD
);

    localparam int LINE_W   = NUM_PIXELS * PIXEL_BITS;
    localparam int HP_MAX_V = int'(lfm_hp_max(CLOCK_FREQ, LOW_FREQ));
    localparam int HP_W     = (HP_MAX_V < 2) ? 1 : $clog2(HP_MAX_V + 1);
    localparam int TABLE_N  = 2 ** PIXEL_BITS;

    localparam logic [HP_W-1:0] HP_ZERO =
        HP_W'(lfm_hp(0, PIXEL_BITS, CLOCK_FREQ, LOW_FREQ, HIGH_FREQ));

    logic [LINE_W-1:0] shift_r;
    logic [LINE_W-1:0] data_r;
    logic              clear_s;
    logic [HP_W-1:0]   hp_table [TABLE_N];

    // Constant half-period table, one entry per possible pixel value.
    for (genvar v = 0; v < TABLE_N; v++) begin : g_hp
        assign hp_table[v] = HP_W'(lfm_hp(v, PIXEL_BITS, CLOCK_FREQ, LOW_FREQ, HIGH_FREQ));
    end

`ifdef LFM_CLEAR_ON_LOAD_EN
    assign clear_s = LOAD;
`else
    assign clear_s = 1'b0;
`endif

    // Shift stage and line register; LOAD freezes the shift stage while copying.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_r <= '0;
            data_r  <= '0;
        end else if (LOAD) begin
            data_r  <= shift_r;
        end else begin
            shift_r <= {shift_r[LINE_W-2:0], SHIFT_IN};
        end
    end

    assign DATA_OUT = data_r;

    for (genvar p = 0; p < NUM_PIXELS; p++) begin : g_pix
        logic [PIXEL_BITS-1:0] pixel_s;
        assign pixel_s = data_r[PIXEL_BITS*p +: PIXEL_BITS];

        line_pixel_channel #(
            .PIXEL_BITS   (PIXEL_BITS),
            .COUNTER_BITS (COUNTER_BITS),
            .HP_W         (HP_W),
            .HP_RESET     (HP_ZERO)
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .clear     (clear_s),
            .pixel     (pixel_s),
            .hp        (hp_table[pixel_s]),
            .freq_out  (FREQ_OUT[p]),
            .time_high (TIME_HIGH[COUNTER_BITS*p +: COUNTER_BITS]),
            .time_low  (TIME_LOW[COUNTER_BITS*p +: COUNTER_BITS]),
            .period    (PERIOD[COUNTER_BITS*p +: COUNTER_BITS])
        );
    end

endmodule

// File: tb/tb_line_frequency_measure.sv
// -----------------------------------------------------------------------------
// tb_line_frequency_measure
// Directed bench for line_frequency_measure with NUM_PIXELS=4, plus a second
// single-pixel instance with 8-bit counters for the saturation case.
// Expected values are queued when stimulus is applied and popped when the
// corresponding output is sampled (#1 after the rising edge).
// -----------------------------------------------------------------------------
module tb_line_frequency_measure;

    localparam int NP = 4;
    localparam int PB = 8;
    localparam int CB = 15;
    localparam int LW = NP * PB;

    // independent model of the half-period law at the default frequencies
    localparam int HP_MAX_B   = 50_000_000 / (2 * 10_001);
    localparam int HP_MIN_RAW = 50_000_000 / (2 * 20_000_000);
    localparam int HP_MIN_B   = (HP_MIN_RAW < 1) ? 1 : HP_MIN_RAW;

    logic            clk = 1'b0;
    logic            rst;
    logic            shift_in;
    logic            load;
    logic [LW-1:0]   data_out;
    logic [NP-1:0]   freq_out;
    logic [NP*CB-1:0] time_high;
    logic [NP*CB-1:0] time_low;
    logic [NP*CB-1:0] period;

    logic [7:0]      s_data;
    logic [0:0]      s_freq;
    logic [7:0]      s_th;
    logic [7:0]      s_tl;
    logic [7:0]      s_per;

    always #5 clk = ~clk;

    line_frequency_measure #(.NUM_PIXELS(NP), .PIXEL_BITS(PB), .COUNTER_BITS(CB)) dut (
        .CLK(clk), .RST(rst), .SHIFT_IN(shift_in), .LOAD(load),
        .DATA_OUT(data_out), .FREQ_OUT(freq_out),
        .TIME_HIGH(time_high), .TIME_LOW(time_low), .PERIOD(period)
    );

    line_frequency_measure #(.NUM_PIXELS(1), .PIXEL_BITS(PB), .COUNTER_BITS(8)) dut_sat (
        .CLK(clk), .RST(rst), .SHIFT_IN(1'b0), .LOAD(1'b0),
        .DATA_OUT(s_data), .FREQ_OUT(s_freq),
        .TIME_HIGH(s_th), .TIME_LOW(s_tl), .PERIOD(s_per)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   rises;
    int   budget;
    logic prev_f;
    logic early;
    logic f3;

    function automatic int hp_model(input int v);
        return HP_MAX_B - ((HP_MAX_B - HP_MIN_B) * v) / 255;
    endfunction

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    function automatic logic [CB-1:0] fld(input logic [NP*CB-1:0] bus, input int idx);
        return bus[CB*idx +: CB];
    endfunction

    function automatic logic [PB-1:0] pix(input logic [LW-1:0] bus, input int idx);
        return bus[PB*idx +: PB];
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] observed);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed %0d, nothing expected", observed);
        end else begin
            e = exp_q.pop_front();
            assert (observed === e.value) else begin
                n_fail++;
                $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                       e.tag, observed, observed, e.value, e.value);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic shift_word(input logic [31:0] w);
        load = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            shift_in = w[i];
            tick(1);
        end
        shift_in = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        shift_in = 1'b0;
        load     = 1'b0;
        tick(3);

        // reset state
        expect_val("reset_data_out", 32'h0);
        check_next(data_out);
        expect_val("reset_freq_out", 32'h0);
        check_next(32'(freq_out));
        expect_val("reset_measurements", 32'h0);
        check_next({29'd0, |time_high, |time_low, |period});

        // reset in the middle of a line
        rst = 1'b0;
        shift_in = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(2);
        expect_val("midline_reset_outputs", 32'h0);
        check_next({28'd0, |data_out, |time_high, |time_low, |period});
        rst = 1'b0;
        shift_in = 1'b0;
        expect_val("reset_discards_shift", 32'h0);
        pulse_load();
        check_next(data_out);

        // no commit until the second rise of pixel 0's wave
        rises  = 0;
        budget = 0;
        early  = 1'b0;
        prev_f = freq_out[0];
        while (rises < 2 && budget < 10000) begin
            tick(1);
            budget++;
            if (freq_out[0] && !prev_f) rises++;
            prev_f = freq_out[0];
            if (fld(period, 0) != '0) early = 1'b1;
        end
        expect_val("no_commit_before_second_rise", 32'h0);
        check_next(32'(early));
        expect_val("second_rise_within_budget", 32'd2);
        check_next(32'(rises));
        tick(3);
        expect_val("first_period_pix0", 32'(2 * hp_model(0)));
        check_next(32'(fld(period, 0)));
        expect_val("first_high_pix0", 32'(hp_model(0)));
        check_next(32'(fld(time_high, 0)));

        // saturation with 8-bit counters
        expect_val("sat_period", 32'(sat8(2 * hp_model(0))));
        check_next(32'(s_per));
        expect_val("sat_high", 32'(sat8(hp_model(0))));
        check_next(32'(s_th));
        expect_val("sat_low", 32'(sat8(hp_model(0))));
        check_next(32'(s_tl));

        // shift and load
        shift_word(32'hFF80_0010);
        expect_val("load_data_out", 32'hFF80_0010);
        pulse_load();
        check_next(data_out);
        expect_val("load_pixel0", 32'h10);
        check_next(32'(pix(data_out, 0)));
        expect_val("load_pixel3", 32'hFF);
        check_next(32'(pix(data_out, 3)));

        // LOAD has priority: two LOAD cycles with SHIFT_IN=1 leave the stage alone
        shift_in = 1'b1;
        load     = 1'b1;
        tick(1);
        tick(1);
        expect_val("load_priority_hold", 32'hFF80_0010);
        check_next(data_out);
        load     = 1'b0;
        shift_in = 1'b0;
        tick(1);
        expect_val("shift_after_priority", 32'hFF00_0020);
        pulse_load();
        check_next(data_out);

        // steady-state measurement
        shift_word(32'hFF80_0000);
        expect_val("meas_data_out", 32'hFF80_0000);
        pulse_load();
        check_next(data_out);
        tick(12000);
        expect_val("pix3_period", 32'(2 * hp_model(255)));
        check_next(32'(fld(period, 3)));
        expect_val("pix3_high", 32'(hp_model(255)));
        check_next(32'(fld(time_high, 3)));
        expect_val("pix3_low", 32'(hp_model(255)));
        check_next(32'(fld(time_low, 3)));
        expect_val("pix2_period", 32'(2 * hp_model(128)));
        check_next(32'(fld(period, 2)));
        expect_val("pix2_high", 32'(hp_model(128)));
        check_next(32'(fld(time_high, 2)));
        expect_val("pix1_period", 32'(2 * hp_model(0)));
        check_next(32'(fld(period, 1)));
        expect_val("pix0_period", 32'(2 * hp_model(0)));
        check_next(32'(fld(period, 0)));
        f3 = freq_out[3];
        tick(1);
        expect_val("pix3_toggles_each_cycle", 32'd1);
        check_next(32'(freq_out[3] ^ f3));

        // behaviour of measurements across a new LOAD
        shift_word(32'h00FF_0000);
        pulse_load();
        expect_val("reload_data_out", 32'h00FF_0000);
        check_next(data_out);
`ifdef LFM_CLEAR_ON_LOAD_EN
        expect_val("reload_pix2_period", 32'h0);
        expect_val("reload_pix3_high", 32'h0);
`else
        expect_val("reload_pix2_period", 32'(2 * hp_model(128)));
        expect_val("reload_pix3_high", 32'(hp_model(255)));
`endif
        check_next(32'(fld(period, 2)));
        check_next(32'(fld(time_high, 3)));
        tick(20);
        expect_val("reload_pix2_new_period", 32'(2 * hp_model(255)));
        check_next(32'(fld(period, 2)));
        expect_val("reload_pix2_new_low", 32'(hp_model(255)));
        check_next(32'(fld(time_low, 2)));

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drained: observed %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
